// File: rtl/acc_arb_pkg.sv
// Shared constants for the accumulator writeback bus arbiter: default widths,
// output-stage state encoding and requester indices.
package acc_arb_pkg;

  localparam int unsigned DEF_DATA_W = 34;
  localparam int unsigned DEF_CNT_W  = 16;

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/acc_bus_arbiter_rr_arb2.sv
// Combinational two-way round-robin arbiter: on contention the requester that
// did not win last time is granted.
module rr_arb2
  import acc_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_gnt,
  output logic       gnt_vld,
  output logic       gnt_idx
);

  always_comb begin
    gnt_vld = |valid;
    if (&valid) begin
      gnt_idx = ~last_gnt;
    end else if (valid[1]) begin
      gnt_idx = REQ1;
    end else begin
      gnt_idx = REQ0;
    end
  end

endmodule

// File: rtl/acc_bus_arbiter.sv
// Two-requester round-robin arbiter with a one-entry registered output stage
// for the accumulator writeback bus. Define ACC_ARB_STATS_EN for grant counters.
module acc_bus_arbiter
  import acc_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  input  logic              out_ready,
  output logic              mux_sel
`ifdef ACC_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1
`endif
);

  logic state_q;
  logic last_gnt_q;
  logic gnt_vld;
  logic gnt_idx;
  logic load;
  logic xfer;
  logic [DATA_W-1:0] sel_data;

  rr_arb2 u_rr_arb2 (
    .valid    ({req1_valid, req0_valid}),
    .last_gnt (last_gnt_q),
    .gnt_vld  (gnt_vld),
    .gnt_idx  (gnt_idx)
  );

  // Gating with rst_n keeps any handshake from completing while reset is held.
  assign load       = rst_n & ((state_q == EMPTY) | out_ready);
  assign xfer       = load & gnt_vld;
  assign req0_ready = xfer & (gnt_idx == REQ0) & req0_valid;
  assign req1_ready = xfer & (gnt_idx == REQ1) & req1_valid;
  assign mux_sel    = gnt_vld ? gnt_idx : last_gnt_q;
  assign sel_data   = mux_sel ? req1_data : req0_data;
  assign out_valid  = (state_q == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      last_gnt_q <= REQ1;
      out_data   <= '0;
      out_src    <= REQ0;
    end else if (xfer) begin
      state_q    <= FULL;
      last_gnt_q <= gnt_idx;
      out_data   <= sel_data;
      out_src    <= gnt_idx;
    end else if ((state_q == FULL) && out_ready) begin
      state_q <= EMPTY;
    end
  end

`ifdef ACC_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (req0_ready && (gnt_cnt0 != '1)) gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
      if (req1_ready && (gnt_cnt1 != '1)) gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_acc_bus_arbiter.sv
// Self-checking bench for acc_bus_arbiter: directed steps then random traffic
// against a transaction-level reference model. Honors ACC_ARB_STATS_EN.
module tb_acc_bus_arbiter;

  localparam int unsigned DW = 34;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_src;
  logic          out_ready;
  logic          mux_sel;
`ifdef ACC_ARB_STATS_EN
  logic [CW-1:0] gnt_cnt0, gnt_cnt1;
`endif

  acc_bus_arbiter #(
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .mux_sel    (mux_sel)
`ifdef ACC_ARB_STATS_EN
    ,
    .gnt_cnt0   (gnt_cnt0),
    .gnt_cnt1   (gnt_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a one-word holding slot plus the identity of the last winner.
  bit          m_full;
  logic [DW-1:0] m_data;
  bit          m_src;
  bit          m_last;
  int          m_cnt0, m_cnt1;
  bit          e_r0, e_r1, e_sel;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_data = '0; m_src = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
  endtask

  // One clock: check combinational handshake, advance the model, check registers.
  task automatic cycle_check(input string tag);
    bit can_take, any, win;
    #2;
    can_take = !m_full || out_ready;
    any = req0_valid || req1_valid;
    if (req0_valid && req1_valid) win = (m_last == 1) ? 1'b0 : 1'b1;
    else win = req1_valid;
    e_r0  = can_take && any && !win;
    e_r1  = can_take && any && win;
    e_sel = any ? win : m_last;
    chk({tag, ".req0_ready"}, 64'(req0_ready), 64'(e_r0));
    chk({tag, ".req1_ready"}, 64'(req1_ready), 64'(e_r1));
    chk({tag, ".mux_sel"}, 64'(mux_sel), 64'(e_sel));
    if (can_take && any) begin
      m_data = win ? req1_data : req0_data;
      m_src  = win;
      m_last = win;
      m_full = 1;
      if (win) m_cnt1 = (m_cnt1 < (2**CW - 1)) ? m_cnt1 + 1 : m_cnt1;
      else     m_cnt0 = (m_cnt0 < (2**CW - 1)) ? m_cnt0 + 1 : m_cnt0;
    end else if (m_full && out_ready) begin
      m_full = 0;
    end
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_full));
    chk({tag, ".out_data"}, 64'(out_data), 64'(m_data));
    chk({tag, ".out_src"}, 64'(out_src), 64'(m_src));
`ifdef ACC_ARB_STATS_EN
    chk({tag, ".gnt_cnt0"}, 64'(gnt_cnt0), 64'(m_cnt0));
    chk({tag, ".gnt_cnt1"}, 64'(gnt_cnt1), 64'(m_cnt1));
`endif
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.out_data", 64'(out_data), 64'd0);
    chk("rst.out_src", 64'(out_src), 64'd0);
    chk("rst.req0_ready", 64'(req0_ready), 64'd0);
    chk("rst.req1_ready", 64'(req1_ready), 64'd0);
`ifdef ACC_ARB_STATS_EN
    chk("rst.gnt_cnt0", 64'(gnt_cnt0), 64'd0);
    chk("rst.gnt_cnt1", 64'(gnt_cnt1), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] rnd;
    req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0; out_ready = 0;

    // Reset with both requesters valid: nothing may be accepted.
    req0_valid = 1; req1_valid = 1;
    req0_data = 34'hA; req1_data = 34'hB;
    apply_reset();

    // Contention, then requester 0 must win the first tie: expect 0,1,0,1.
    out_ready = 1;
    cycle_check("cont0");
    chk("cont0.src", 64'(out_src), 64'd0);
    chk("cont0.data", 64'(out_data), 64'hA);
    cycle_check("cont1");
    chk("cont1.src", 64'(out_src), 64'd1);
    cycle_check("cont2");
    chk("cont2.src", 64'(out_src), 64'd0);
    cycle_check("cont3");
    chk("cont3.data", 64'(out_data), 64'hB);

    // Drain to empty.
    req0_valid = 0; req1_valid = 0;
    cycle_check("drain");
    chk("drain.out_valid", 64'(out_valid), 64'd0);

    // Single requester 1 with a wide payload.
    req1_valid = 1; req1_data = 34'h2_0000_0001;
    cycle_check("single");
    chk("single.data", 64'(out_data), 64'h2_0000_0001);
    req1_valid = 0;
    cycle_check("single_drain");

    // Backpressure: word held three cycles while requester 1 waits.
    out_ready = 0;
    req0_valid = 1; req0_data = 34'h5;
    cycle_check("bp_load");
    req0_valid = 0;
    req1_valid = 1; req1_data = 34'h6;
    for (int i = 0; i < 3; i++) cycle_check("bp_stall");
    chk("bp.held_data", 64'(out_data), 64'h5);
    out_ready = 1;
    cycle_check("bp_release");
    chk("bp_release.data", 64'(out_data), 64'h6);
    req1_valid = 0;
    cycle_check("bp_drain");

    // Random traffic obeying the hold-until-ready rule.
    for (int n = 0; n < 400; n++) begin
      if (!req0_valid && ($urandom % 3 != 0)) begin
        rnd = {$urandom(), $urandom()};
        req0_valid = 1; req0_data = rnd[DW-1:0];
      end
      if (!req1_valid && ($urandom % 3 != 0)) begin
        rnd = {$urandom(), $urandom()};
        req1_valid = 1; req1_data = rnd[DW-1:0];
      end
      out_ready = ($urandom % 4) != 0;
      cycle_check("rand");
      if (e_r0) req0_valid = 0;
      if (e_r1) req1_valid = 0;
    end

`ifdef ACC_ARB_STATS_EN
    // Counter saturation, then clear by reset.
    req0_valid = 0; req1_valid = 0; out_ready = 1;
    apply_reset();
    req0_valid = 1;
    for (int n = 0; n < 20; n++) begin
      req0_data = DW'(n);
      cycle_check("sat");
    end
    chk("sat.cnt0", 64'(gnt_cnt0), 64'(2**CW - 1));
    chk("sat.cnt1", 64'(gnt_cnt1), 64'd0);
    req0_valid = 0;
    apply_reset();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
